if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Producer side of the IF/ID pipeline register: generates the PC, issues instruction-memory reads and buffers the returned words.
- Presents `instr`/`npc` pairs to IF/ID.
- Honours `stall` from the hazard unit and `redirect` (taken branch/jump) from EX.
- Sits between instruction memory and the IF/ID register.

Parameters:
- XLEN, 32, datapath/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, min 2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request present
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  read data valid (one response per accepted request, in order, latency ≥1)
- imem_rsp_data  in  XLEN  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored
- stall  in  1  IF/ID not accepting this cycle
- instr  out  XLEN  instruction to IF/ID
- npc  out  XLEN  fetch address of `instr` + 4
- instr_valid  out  1  `instr`/`npc` valid

Behaviour:
- Reset (asynchronous, `reset`=0):
  - pc=RESET_PC, FIFO empty, FSM=IDLE.
  - imem_req_valid=0, instr=0, npc=0, instr_valid=0.
- Single outstanding request, tracked by FSM:
  - IDLE:
    - issue when (fifo_count + 0) < FIFO_DEPTH and not redirecting.
    - imem_req_valid=1, addr=pc.
    - On accept (valid&ready) → WAIT; pc<=pc+4.
  - WAIT:
    - imem_rsp_valid → push {rsp_data, addr} into FIFO.
    - Then IDLE, or issue the next request in the same cycle if space remains after the push.
  - DISCARD:
    - imem_rsp_valid → drop the data, then IDLE.
    - No push.
- Request not yet accepted:
  - Address held stable while valid=1 unless a redirect occurs.
  - On redirect the request is withdrawn and reissued from redirect_pc the next cycle; instruction memory tolerates this.
- Downstream:
  - instr_valid = FIFO non-empty.
  - instr/npc = head entry ({data, addr+4}).
  - Pop when instr_valid & !stall.
  - FIFO empty → instr=0, npc=0.
- Latency: accept at cycle T, rsp at T+1 → written to FIFO at T+1 edge → instr_valid at T+2. No bypass.
- Full: the credit rule (count + outstanding ≤ FIFO_DEPTH) guarantees a response never finds the FIFO full.
- Simultaneous push and pop on a full FIFO is legal; count unchanged.
- Redirect (highest priority):
  - Same cycle: FIFO flushed (count=0, instr_valid=0 next cycle), pc<=redirect_pc & ~3.
  - WAIT → DISCARD if the response has not arrived this cycle.
  - A response arriving in the redirect cycle is dropped.
  - Fetch from the new pc may issue the cycle after the redirect.
  - Redirect during stall: redirect wins; held head discarded.
  - Redirect during DISCARD: pc updated, stays DISCARD.
- Wrap: pc 32'hFFFF_FFFC + 4 → 32'h0000_0000. npc wraps identically.
- Reset mid-operation: all state cleared immediately. A response arriving after reset release with no request outstanding is ignored.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, RESET_PC default, INSTR_BYTES=4.
  - Fetch FSM enum {IDLE, WAIT, DISCARD}.
- One sub-module: fetch_fifo.
  - Synchronous FIFO of {instr, pc}, width 2·XLEN, depth FIFO_DEPTH.
  - push/pop/flush ports, count output.
  - Flush overrides push.
  - Same async active-low reset.

Test Plan:
1. Reset release, zero-wait memory (ready=1, rsp next cycle), stall=0:
   - addrs 0x0, 0x4, 0x8…
   - First instr_valid two cycles after first accept.
   - npc=0x4, 0x8, 0xC in order.
2. stall=1 for 5 cycles after first valid:
   - FIFO fills to 2, imem_req_valid drops.
   - Head held (instr at 0x0, npc=0x4).
   - On release, entries 0x0, 0x4 pop back-to-back, fetch resumes at 0x8.
3. redirect_valid with redirect_pc=0x103 while WAIT for 0x8:
   - 0x8 response discarded, FIFO flushed.
   - Next request addr=0x100.
   - First delivered npc=0x104.
4. Redirect in the same cycle as rsp_valid, plus redirect while req_valid=1 & ready=0:
   - Data never appears on instr.
   - Pending request reissued with the new address.
5. RESET_PC=32'hFFFF_FFF8:
   - Addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
   - npc 0xFFFF_FFFC, 0x0, 0x4.
6. Assert reset=0 with FIFO holding 2 entries and one request outstanding:
   - instr_valid=0, imem_req_valid=0 immediately.
   - After release, fetch restarts at RESET_PC.
   - Stale rsp_valid ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

   localparam int          XLEN_DEFAULT     = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          INSTR_BYTES      = 4;

   // IDLE: nothing outstanding; WAIT: one request outstanding whose data is wanted;
   // DISCARD: one request outstanding whose data must be thrown away.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {instr, pc} prefetch entries.
// Latency: a push is visible on rdata_o/count_o the cycle after it is written.
// Backpressure: none internally; the owner guarantees a push never meets a full FIFO
//   unless a pop happens in the same cycle. flush_i overrides push_i and pop_i.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i write side;
//   pop_i read side; flush_i empties the FIFO; rdata_o head entry; count_o occupancy.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: count_q gates every use of the contents.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: generates PC, issues single-outstanding imem reads, buffers words for IF/ID.
// Latency: request accepted in cycle T, response in T+1, instr_valid in T+2 (no bypass).
// Backpressure: stall holds the FIFO head; requests only issue while the FIFO has a free credit.
// Ports: clock/reset (async active-low); imem_req_* request channel (valid/ready, addr);
//   imem_rsp_* in-order responses; redirect_* flush and restart from a new pc;
//   stall from hazard unit; instr/npc/instr_valid towards IF/ID.
module if_fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN       = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clock,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] npc,
   output logic            instr_valid
);

   localparam int              CW      = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;   // address of the outstanding request
   logic            run_q;                    // keeps the request channel quiet for one cycle after reset

   logic            req_vld;
   logic            fifo_push, fifo_pop, fifo_flush, fifo_nonempty;
   logic [2*XLEN-1:0] fifo_head;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     count_after;

   assign fifo_nonempty = (fifo_count != '0);
   assign fifo_pop      = fifo_nonempty && !stall;
   assign fifo_flush    = redirect_valid;
   // Occupancy after this cycle's response is written and the head (maybe) leaves.
   assign count_after   = {1'b0, fifo_count} + (CW+1)'(1) - (CW+1)'(fifo_pop);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      req_vld    = 1'b0;
      fifo_push  = 1'b0;

      if (redirect_valid) begin
         // Low address bits are forced to zero by masking with ~(INSTR_BYTES-1).
         pc_d = redirect_pc & ~(STEP - XLEN'(1));
         // A request still in flight must have its data dropped when it finally returns.
         if ((state_q != IDLE) && !imem_rsp_valid) state_d = DISCARD;
         else                                      state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (run_q && (fifo_count < DEPTH_C)) req_vld = 1'b1;
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  fifo_push = 1'b1;
                  state_d   = IDLE;
                  if (count_after < {1'b0, DEPTH_C}) req_vld = 1'b1;
               end
            end
            DISCARD: begin
               if (imem_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase

         if (req_vld && imem_req_ready) begin
            state_d    = WAIT;
            req_addr_d = pc_q;
            pc_d       = pc_q + STEP;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= '0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         run_q      <= 1'b1;
      end
   end

   fetch_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .push_i  (fifo_push),
      .wdata_i ({imem_rsp_data, req_addr_q}),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .rdata_o (fifo_head),
      .count_o (fifo_count)
   );

   assign imem_req_valid = req_vld;
   assign imem_req_addr  = pc_q;
   assign instr_valid    = fifo_nonempty;
   assign instr          = fifo_nonempty ? fifo_head[2*XLEN-1:XLEN]      : '0;
   assign npc            = fifo_nonempty ? (fifo_head[XLEN-1:0] + STEP)  : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal checks, then random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_if_fetch_unit;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic [31:0] instr, npc;
   logic        instr_valid;

   always #5 clock = ~clock;

   if_fetch_unit #(
      .XLEN       (32),
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .instr          (instr),
      .npc            (npc),
      .instr_valid    (instr_valid)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: buffered entries, the pc, and whether a request is in flight.
   typedef struct packed { logic [31:0] d; logic [31:0] a; } ent_t;
   ent_t        mq[$];
   bit          m_run, m_out, m_drop;
   logic [31:0] m_pc, m_oaddr;

   // Memory agent.
   int          mem_lat = 1;
   bit          mem_busy = 0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;

   // Snapshot of DUT outputs from the last checked cycle.
   logic        s_req, s_ivld;
   logic [31:0] s_addr, s_npc, s_instr;

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   task automatic step();
      int          sz;
      bit          e_req, pop, push, acc;
      logic [31:0] acc_addr;
      ent_t        ne;
      @(negedge clock);
      sz  = mq.size();
      pop = (sz != 0) && !stall;
      if (!reset) begin
         chk("instr_valid", 32'(instr_valid), 32'd0);
         chk("instr", instr, 32'd0);
         chk("npc", npc, 32'd0);
         chk("req_valid", 32'(imem_req_valid), 32'd0);
         e_req = 1'b0;
      end else begin
         if (!m_run || redirect_valid)            e_req = 1'b0;
         else if (!m_out)                         e_req = (sz < DEPTH);
         else if (imem_rsp_valid && !m_drop)      e_req = ((sz + 1 - int'(pop)) < DEPTH);
         else                                     e_req = 1'b0;
         chk("instr_valid", 32'(instr_valid), 32'(sz != 0));
         chk("instr", instr, (sz != 0) ? mq[0].d : 32'd0);
         chk("npc", npc, (sz != 0) ? mq[0].a + 32'd4 : 32'd0);
         chk("req_valid", 32'(imem_req_valid), 32'(e_req));
         if (e_req) chk("req_addr", imem_req_addr, m_pc);
      end
      s_req = imem_req_valid; s_addr = imem_req_addr; s_ivld = instr_valid;
      s_npc = npc; s_instr = instr;
      acc      = reset && imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;

      // Advance the model across the coming clock edge.
      if (!reset) begin
         mq.delete(); m_run = 0; m_out = 0; m_drop = 0; m_pc = RST_PC;
      end else begin
         if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            if (m_out && !imem_rsp_valid) m_drop = 1;
            else begin m_out = 0; m_drop = 0; end
         end else begin
            push = 0;
            if (m_out && imem_rsp_valid) begin
               push = !m_drop; m_out = 0; m_drop = 0;
            end
            if (pop) void'(mq.pop_front());
            if (push) begin ne.d = imem_rsp_data; ne.a = m_oaddr; mq.push_back(ne); end
            if (e_req && imem_req_ready) begin
               m_out = 1; m_oaddr = m_pc; m_pc = m_pc + 32'd4;
            end
         end
         m_run = 1;
      end

      @(posedge clock);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      if (acc) begin mem_busy = 1; mem_cnt = mem_lat; mem_addr = acc_addr; end
      if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(mem_addr);
            mem_busy       = 0;
         end
      end
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0;
      redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      m_run = 0; m_out = 0; m_drop = 0; m_pc = RST_PC; m_oaddr = '0;

      // Zero-wait streaming from reset.
      repeat (3) step();
      reset = 1'b1;
      step();  chk("t1_req_c0", 32'(s_req), 32'd0);
      step();  chk("t1_req_c1", 32'(s_req), 32'd1); chk("t1_addr_c1", s_addr, 32'h0);
      step();  chk("t1_addr_c2", s_addr, 32'h4);    chk("t1_vld_c2", 32'(s_ivld), 32'd0);
      step();  chk("t1_vld_c3", 32'(s_ivld), 32'd1); chk("t1_npc_c3", s_npc, 32'h4);
               chk("t1_instr_c3", s_instr, word(32'h0));
      step();  chk("t1_npc_c4", s_npc, 32'h8);
      step();  chk("t1_npc_c5", s_npc, 32'hC);

      // Stall fills the buffer, then drains back-to-back.
      reset = 1'b0; repeat (2) step(); reset = 1'b1;
      repeat (3) step();
      stall = 1'b1;
      step();  chk("t2_npc_c3", s_npc, 32'h4);
      step();  chk("t2_req_c4", 32'(s_req), 32'd0);
      repeat (3) step();
      chk("t2_npc_c7", s_npc, 32'h4); chk("t2_vld_c7", 32'(s_ivld), 32'd1);
      stall = 1'b0;
      step();  chk("t2_npc_c8", s_npc, 32'h4); chk("t2_req_c8", 32'(s_req), 32'd0);
      mem_lat = 2;
      step();  chk("t2_npc_c9", s_npc, 32'h8); chk("t2_addr_c9", s_addr, 32'h8);
      mem_lat = 1;

      // Redirect while waiting for 0x8.
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      step();  chk("t3_req_c10", 32'(s_req), 32'd0);
      redirect_valid = 1'b0;
      step();  chk("t3_req_c11", 32'(s_req), 32'd0); chk("t3_vld_c11", 32'(s_ivld), 32'd0);
      step();  chk("t3_req_c12", 32'(s_req), 32'd1); chk("t3_addr_c12", s_addr, 32'h100);
      step();  chk("t3_addr_c13", s_addr, 32'h104);

      // Redirect coinciding with a response, then redirect of a stalled request.
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      step();  chk("t4_npc_c14", s_npc, 32'h104); chk("t4_instr_c14", s_instr, word(32'h100));
      redirect_valid = 1'b0; imem_req_ready = 1'b0;
      step();  chk("t4_req_c15", 32'(s_req), 32'd1); chk("t4_addr_c15", s_addr, 32'h200);
      redirect_valid = 1'b1; redirect_pc = 32'h300;
      step();  chk("t4_req_c16", 32'(s_req), 32'd0);
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      step();  chk("t4_addr_c17", s_addr, 32'h300);
      step();  chk("t4_vld_c18", 32'(s_ivld), 32'd0);
      step();  chk("t4_npc_c19", s_npc, 32'h304); chk("t4_instr_c19", s_instr, word(32'h300));

      // Address wrap.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB;
      step();
      redirect_valid = 1'b0;
      step();  chk("t5_addr_c21", s_addr, 32'hFFFF_FFF8);
      step();  chk("t5_addr_c22", s_addr, 32'hFFFF_FFFC);
      step();  chk("t5_addr_c23", s_addr, 32'h0); chk("t5_npc_c23", s_npc, 32'hFFFF_FFFC);
      step();  chk("t5_npc_c24", s_npc, 32'h0);
      step();  chk("t5_npc_c25", s_npc, 32'h4);

      // Reset mid-operation with data buffered and a request in flight.
      stall = 1'b1; mem_lat = 3;
      repeat (4) step();
      reset = 1'b0;
      step();  chk("t6_vld_rst", 32'(s_ivld), 32'd0); chk("t6_req_rst", 32'(s_req), 32'd0);
      step();
      reset = 1'b1; stall = 1'b0; mem_lat = 1;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
      step();  chk("t6_req_c0", 32'(s_req), 32'd0); chk("t6_vld_c0", 32'(s_ivld), 32'd0);
      step();  chk("t6_addr_c1", s_addr, RST_PC); chk("t6_vld_c1", 32'(s_ivld), 32'd0);
      step();
      step();  chk("t6_npc_c3", s_npc, RST_PC + 32'd4); chk("t6_instr_c3", s_instr, word(RST_PC));

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         stall          = ($urandom_range(0, 99) < 30);
         imem_req_ready = ($urandom_range(0, 99) < 70);
         redirect_valid = ($urandom_range(0, 99) < 5);
         redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom;
         mem_lat        = $urandom_range(1, 3);
         reset          = ($urandom_range(0, 399) != 0);
         step();
      end
      reset = 1'b1; redirect_valid = 1'b0; stall = 1'b0;
      repeat (10) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
